// File: rtl/rcb_frl_pkg.sv
// Shared types and constants for the Fast Radio Link receive-side blocks.
package rcb_frl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_WAIT   = 2'd2,
        ST_LOCKED = 2'd3
    } frl_state_t;

    // Byte the far end transmits while training is active.
    localparam logic [7:0] FRL_TRAIN_BYTE  = 8'h5C;

    // Match count at which the next matching byte declares lock; also the
    // saturation point of the 4-bit match/miss counters.
    localparam logic [3:0] FRL_LOCK_THRESH = 4'd15;

endpackage

// File: rtl/rcb_frl_match_counter.sv
// 4-bit event counter with synchronous clear and saturation at 15.
module rcb_frl_match_counter
    import rcb_frl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       inc,
    output logic [3:0] cnt
);

    // Clear has priority over increment; increment stops at the threshold.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (inc && (cnt != FRL_LOCK_THRESH)) begin
            cnt <= cnt + 4'd1;
        end
    end

endmodule

// File: rtl/rcb_frl_train_align.sv
// Word-alignment controller: hunts for the training byte by bitslipping the
// deserializer until 16 consecutive matches are seen, then holds lock.
module rcb_frl_train_align
    import rcb_frl_pkg::*;
#(
    parameter logic [7:0]  TRAIN_PATTERN = FRL_TRAIN_BYTE,
    parameter int unsigned SLIP_WAIT     = 3,
    parameter int unsigned LOSS_LIMIT    = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] din,
    input  logic       din_vld,
    input  logic       train_en,
    output logic       bitslip,
    output logic [3:0] match_cnt,
    output logic [2:0] slip_cnt,
    output logic       locked,
    output logic       align_err
);

    localparam logic [3:0] SLIP_WAIT_L = 4'(SLIP_WAIT);
    localparam logic [3:0] LOSS_LAST   = 4'(LOSS_LIMIT - 1);

    frl_state_t state_q;
    frl_state_t state_d;

    logic [3:0] wait_q;
    logic [3:0] miss_cnt;
    logic       is_match;
    logic       slip_fire;
    logic       loss;
    logic       hunt_inc;
    logic       miss_inc;
    logic       miss_clr;
    logic       to_idle;

    assign is_match = (din == TRAIN_PATTERN);
    assign to_idle  = (state_d == ST_IDLE);

    // Next-state decode plus single-cycle strobes for the counters.
    always_comb begin
        state_d   = state_q;
        slip_fire = 1'b0;
        loss      = 1'b0;
        hunt_inc  = 1'b0;
        miss_inc  = 1'b0;
        miss_clr  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (train_en) begin
                    state_d = ST_HUNT;
                end
            end
            ST_HUNT: begin
                // The 16th match locks even if training ends on the same edge.
                if (din_vld && is_match && (match_cnt == FRL_LOCK_THRESH)) begin
                    state_d = ST_LOCKED;
                end else if (!train_en) begin
                    state_d = ST_IDLE;
                end else if (din_vld) begin
                    if (is_match) begin
                        hunt_inc = 1'b1;
                    end else begin
                        slip_fire = 1'b1;
                        state_d   = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (!train_en) begin
                    state_d = ST_IDLE;
                end else if (wait_q <= 4'd1) begin
                    state_d = ST_HUNT;
                end
            end
            ST_LOCKED: begin
                if (train_en && din_vld) begin
                    if (is_match) begin
                        miss_clr = 1'b1;
                    end else if (miss_cnt == LOSS_LAST) begin
                        loss    = 1'b1;
                        state_d = ST_HUNT;
                    end else begin
                        miss_inc = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Deserializer settle countdown, loaded by each bitslip.
    always_ff @(posedge clk) begin
        if (rst) begin
            wait_q <= '0;
        end else if (slip_fire) begin
            wait_q <= SLIP_WAIT_L;
        end else if ((state_q == ST_WAIT) && (wait_q != 4'd0)) begin
            wait_q <= wait_q - 4'd1;
        end
    end

    // Wrapping slip counter; a wrap to zero marks a sticky alignment error.
    always_ff @(posedge clk) begin
        if (rst || to_idle) begin
            slip_cnt  <= '0;
            align_err <= 1'b0;
        end else if (slip_fire) begin
            slip_cnt <= slip_cnt + 3'd1;
            if (slip_cnt == 3'd7) begin
                align_err <= 1'b1;
            end
        end
    end

    // Registered bitslip pulse and lock flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            bitslip <= 1'b0;
            locked  <= 1'b0;
        end else begin
            bitslip <= slip_fire;
            locked  <= (state_d == ST_LOCKED);
        end
    end

    rcb_frl_match_counter u_match_cnt (
        .clk (clk),
        .rst (rst),
        .clr (to_idle || slip_fire || loss),
        .inc (hunt_inc),
        .cnt (match_cnt)
    );

    rcb_frl_match_counter u_miss_cnt (
        .clk (clk),
        .rst (rst),
        .clr (to_idle || loss || miss_clr),
        .inc (miss_inc),
        .cnt (miss_cnt)
    );

endmodule

// File: tb/tb_rcb_frl_train_align.sv
// Scoreboard bench for rcb_frl_train_align: each driven cycle queues the
// expected registered outputs; a monitor compares them on the falling edge.
module tb_rcb_frl_train_align;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] din = 8'h00;
    logic       din_vld = 1'b0;
    logic       train_en = 1'b0;
    logic       bitslip;
    logic [3:0] match_cnt;
    logic [2:0] slip_cnt;
    logic       locked;
    logic       align_err;

    rcb_frl_train_align #(
        .TRAIN_PATTERN (8'h5C),
        .SLIP_WAIT     (3),
        .LOSS_LIMIT    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .din       (din),
        .din_vld   (din_vld),
        .train_en  (train_en),
        .bitslip   (bitslip),
        .match_cnt (match_cnt),
        .slip_cnt  (slip_cnt),
        .locked    (locked),
        .align_err (align_err)
    );

    always #5 clk = ~clk;

    // Expected output state, maintained by the scenario tasks.
    logic       e_bs = 1'b0;
    logic [3:0] e_mc = '0;
    logic [2:0] e_sc = '0;
    logic       e_lk = 1'b0;
    logic       e_ae = 1'b0;
    int         e_miss = 0;

    logic [9:0] exp_v[$];
    string      exp_n[$];

    int n_cmp = 0;
    int n_err = 0;

    // Drive one cycle of inputs and queue the outputs expected after the edge.
    task automatic step(input logic [7:0] d, input logic v, input logic t,
                        input logic r, input string nm);
        @(negedge clk);
        din = d; din_vld = v; train_en = t; rst = r;
        @(posedge clk);
        #1;
        exp_v.push_back({e_bs, e_mc, e_sc, e_lk, e_ae});
        exp_n.push_back(nm);
    endtask

    task automatic do_reset(input string nm);
        e_bs = 0; e_mc = 0; e_sc = 0; e_lk = 0; e_ae = 0; e_miss = 0;
        step(8'h00, 1'b0, 1'b0, 1'b1, nm);
    endtask

    task automatic enter_hunt();
        e_bs = 0;
        step(8'h00, 1'b0, 1'b1, 1'b0, "idle_to_hunt");
    endtask

    task automatic hunt_match(input string nm);
        e_bs = 0;
        if (e_mc == 4'd15) e_lk = 1;
        else e_mc = e_mc + 4'd1;
        step(8'h5C, 1'b1, 1'b1, 1'b0, nm);
    endtask

    task automatic hunt_gap();
        e_bs = 0;
        step(8'hAE, 1'b0, 1'b1, 1'b0, "hunt_gap_hold");
    endtask

    // Mismatch in HUNT followed by the three WAIT cycles whose bytes are ignored.
    task automatic hunt_miss(input logic [7:0] d, input logic wait_vld, input string nm);
        e_bs = 1; e_mc = 0;
        if (e_sc == 3'd7) e_ae = 1;
        e_sc = e_sc + 3'd1;
        step(d, 1'b1, 1'b1, 1'b0, nm);
        e_bs = 0;
        for (int i = 0; i < 3; i++) step(8'hAE, wait_vld, 1'b1, 1'b0, "wait_ignore");
    endtask

    task automatic lock_sample(input logic m, input string nm);
        e_bs = 0;
        if (m) e_miss = 0;
        else e_miss++;
        if (e_miss == 4) begin
            e_lk = 0; e_mc = 0; e_miss = 0;
        end
        step(m ? 8'h5C : 8'h3A, 1'b1, 1'b1, 1'b0, nm);
    endtask

    // Monitor: compare one queued expectation per falling edge.
    initial begin
        logic [9:0] ev;
        logic [9:0] av;
        string      en;
        forever begin
            @(negedge clk);
            if (exp_v.size() > 0) begin
                ev = exp_v.pop_front();
                en = exp_n.pop_front();
                av = {bitslip, match_cnt, slip_cnt, locked, align_err};
                n_cmp++;
                if (av !== ev) begin
                    n_err++;
                    $display("FAIL %s @%0t: got bs=%0b mc=%0d sc=%0d lk=%0b ae=%0b, expected bs=%0b mc=%0d sc=%0d lk=%0b ae=%0b",
                             en, $time, av[9], av[8:5], av[4:2], av[1], av[0],
                             ev[9], ev[8:5], ev[4:2], ev[1], ev[0]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        do_reset("reset");
        do_reset("reset_hold");

        // Clean acquisition with a valid gap in the middle.
        enter_hunt();
        for (int i = 0; i < 7; i++) hunt_match("acq_match");
        hunt_gap();
        hunt_gap();
        for (int i = 0; i < 8; i++) hunt_match("acq_match");
        hunt_match("acq_16th_lock");

        // Payload mode: lock holds regardless of data.
        for (int i = 0; i < 100; i++) begin
            e_bs = 0;
            step(8'($urandom), 1'($urandom), 1'b0, 1'b0, "payload_hold");
        end

        // Loss-of-lock tolerance: the miss run is broken by a match.
        for (int i = 0; i < 3; i++) lock_sample(1'b0, "lock_miss");
        lock_sample(1'b1, "lock_match_clear");
        for (int i = 0; i < 3; i++) lock_sample(1'b0, "lock_miss");
        lock_sample(1'b0, "lock_loss_4th");

        // Partial match, slip, settle, then reacquire.
        for (int i = 0; i < 5; i++) hunt_match("pre_slip_match");
        hunt_miss(8'hAE, 1'b1, "slip_first");
        for (int i = 0; i < 15; i++) hunt_match("reacq_match");
        hunt_match("reacq_lock");

        // Reset while locked.
        do_reset("rst_mid_locked");

        // Eight slips wrap slip_cnt and raise align_err; hunting continues.
        enter_hunt();
        for (int i = 0; i < 8; i++) hunt_miss(8'h00, 1'(i % 2), "slip_wrap");
        hunt_miss(8'hFF, 1'b1, "slip_after_err");
        hunt_match("match_after_err");
        hunt_match("match_after_err");

        // Mismatch coinciding with train_en low: IDLE, no bitslip, errors cleared.
        e_bs = 0; e_mc = 0; e_sc = 0; e_ae = 0;
        step(8'hAE, 1'b1, 1'b0, 1'b0, "miss_train_off_idle");
        step(8'h5C, 1'b1, 1'b0, 1'b0, "idle_stays");

        // Reset in the middle of WAIT.
        enter_hunt();
        e_bs = 1; e_mc = 0; e_sc = 1;
        step(8'h11, 1'b1, 1'b1, 1'b0, "slip_before_rst");
        e_bs = 0;
        step(8'h5C, 1'b1, 1'b1, 1'b0, "wait_before_rst");
        do_reset("rst_mid_wait");
        enter_hunt();
        hunt_match("post_rst_match");

        // train_en drops on the 16th match: lock is taken and held.
        for (int i = 0; i < 14; i++) hunt_match("edge_match");
        e_bs = 0; e_lk = 1;
        step(8'h5C, 1'b1, 1'b0, 1'b0, "lock_on_train_fall");
        for (int i = 0; i < 4; i++) step(8'h00, 1'b1, 1'b0, 1'b0, "lock_hold_payload");

        // Drain the scoreboard.
        for (int i = 0; i < 4 && exp_v.size() > 0; i++) @(negedge clk);
        @(negedge clk);
        #1;
        if (exp_v.size() != 0) begin
            n_err++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_v.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
